// File: rtl/video_ctrl.sv
// Z80 I/O control block for the VGA adapter: border colour register, frame counter and
// per-frame interrupt request with acknowledge and timeout.
module video_ctrl #(
  parameter logic [7:0]  BORDER_PORT = 8'hFE,
  parameter logic [7:0]  CTRL_PORT   = 8'hFD,
  parameter logic [7:0]  FRAME_PORT  = 8'hFC,
  parameter int unsigned INT_LEN     = 800
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [7:0]  port_a,
  input  logic [7:0]  port_i,
  output logic [7:0]  port_o,
  input  logic        iowr,
  output logic        irq,
  input  logic        irq_ack,
  input  logic        vsync,
  output logic [11:0] border
);

  localparam logic [15:0] LenInit = 16'(INT_LEN - 1);

  logic        iowr_q;
  logic        vs_q;
  logic [2:0]  bidx_q, bidx_d;
  logic [11:0] border_q, border_d;
  logic        ie_q, ie_d;
  logic        ovr_q, ovr_d;
  logic        irq_q, irq_d;
  logic [7:0]  frame_q, frame_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  port_o_q, port_o_d;

  logic wr, rise, wr_border, wr_ctrl;

  // Data bits 5:3 have no meaning in any register.
  logic unused_port_i;
  assign unused_port_i = ^port_i[5:3];

  assign wr        = iowr & ~iowr_q;
  assign rise      = vsync & ~vs_q;
  assign wr_border = wr && (port_a == BORDER_PORT);
  assign wr_ctrl   = wr && (port_a == CTRL_PORT);

  always_comb begin
    bidx_d = wr_border ? port_i[2:0] : bidx_q;
    ie_d   = wr_ctrl ? port_i[0] : ie_q;
  end

  always_comb begin
    unique case (bidx_q)
      3'd0:    border_d = 12'h111;
      3'd1:    border_d = 12'h008;
      3'd2:    border_d = 12'h080;
      3'd3:    border_d = 12'h088;
      3'd4:    border_d = 12'h800;
      3'd5:    border_d = 12'h808;
      3'd6:    border_d = 12'h880;
      default: border_d = 12'hccc;
    endcase
  end

  always_comb begin
    frame_d = frame_q;
    if (wr_ctrl && port_i[7]) begin
      frame_d = 8'h00;
    end else if (rise) begin
      frame_d = frame_q + 8'd1;
    end
  end

  // Later assignments take priority: timeout/ack, then a new frame edge, then CTRL writes.
  always_comb begin
    irq_d = irq_q;
    len_d = len_q;
    ovr_d = ovr_q;
    if (irq_q) begin
      if (irq_ack || (len_q == 16'd0)) begin
        irq_d = 1'b0;
      end else begin
        len_d = len_q - 16'd1;
      end
    end
    if (rise && ie_q) begin
      if (irq_q) begin
        ovr_d = 1'b1;
      end
      irq_d = 1'b1;
      len_d = LenInit;
    end
    if (wr_ctrl) begin
      if (port_i[6]) begin
        ovr_d = 1'b0;
      end
      if (!port_i[0]) begin
        irq_d = 1'b0;
        len_d = 16'd0;
      end
    end
  end

  always_comb begin
    if (port_a == BORDER_PORT) begin
      port_o_d = {5'b0, bidx_q};
    end else if (port_a == CTRL_PORT) begin
      port_o_d = {irq_q, ovr_q, 5'b0, ie_q};
    end else if (port_a == FRAME_PORT) begin
      port_o_d = frame_q;
    end else begin
      port_o_d = 8'hFF;
    end
  end

  // iowr_q/vs_q reset high so levels already asserted at release are not edges.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      iowr_q   <= 1'b1;
      vs_q     <= 1'b1;
      bidx_q   <= 3'd0;
      border_q <= 12'h111;
      ie_q     <= 1'b0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
      frame_q  <= 8'h00;
      len_q    <= 16'd0;
      port_o_q <= 8'hFF;
    end else begin
      iowr_q   <= iowr;
      vs_q     <= vsync;
      bidx_q   <= bidx_d;
      border_q <= border_d;
      ie_q     <= ie_d;
      ovr_q    <= ovr_d;
      irq_q    <= irq_d;
      frame_q  <= frame_d;
      len_q    <= len_d;
      port_o_q <= port_o_d;
    end
  end

  assign port_o = port_o_q;
  assign irq    = irq_q;
  assign border = border_q;

endmodule

// File: tb/tb_video_ctrl.sv
// Directed self-checking bench for video_ctrl: reset, border writes, interrupt timing,
// overrun, counter wrap and same-cycle collisions.
module tb_video_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  port_a;
  logic [7:0]  port_i;
  logic [7:0]  port_o;
  logic        iowr;
  logic        irq;
  logic        irq_ack;
  logic        vsync;
  logic [11:0] border;

  int n_checks;
  int n_fail;

  video_ctrl #(
    .BORDER_PORT (8'hFE),
    .CTRL_PORT   (8'hFD),
    .FRAME_PORT  (8'hFC),
    .INT_LEN     (800)
  ) u_dut (
    .CLOCK   (clk),
    .RESET   (rst),
    .port_a  (port_a),
    .port_i  (port_i),
    .port_o  (port_o),
    .iowr    (iowr),
    .irq     (irq),
    .irq_ack (irq_ack),
    .vsync   (vsync),
    .border  (border)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n active edges; values are sampled 1 time unit after the edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    port_a = addr;
    port_i = data;
    iowr   = 1'b1;
    cyc(1);
    iowr   = 1'b0;
    cyc(1);
  endtask

  task automatic io_read(input logic [7:0] addr, output logic [7:0] data);
    port_a = addr;
    cyc(1);
    data = port_o;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    cyc(1);
    vsync = 1'b0;
  endtask

  // Counts edges until irq falls, starting from k0 already-counted high cycles.
  task automatic irq_high_len(input int k0, output int k);
    k = k0;
    while (irq && k < 2000) begin
      cyc(1);
      k++;
    end
  endtask

  logic [7:0] rd;
  int         k;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    port_a   = 8'hFE;
    port_i   = 8'h07;
    iowr     = 1'b1;
    irq_ack  = 1'b0;
    vsync    = 1'b1;

    // Reset with iowr and vsync already high
    #12;
    check_eq("rst_border", 32'(border), 32'h111);
    check_eq("rst_port_o", 32'(port_o), 32'hFF);
    check_eq("rst_irq", 32'(irq), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(3);
    check_eq("rst_no_write_border", 32'(border), 32'h111);
    check_eq("rst_no_write_read", 32'(port_o), 32'h00);
    iowr  = 1'b0;
    vsync = 1'b0;
    cyc(1);
    io_read(8'hFC, rd);
    check_eq("rst_no_frame", 32'(rd), 32'h00);

    // Border write with iowr held three cycles
    port_a = 8'hFE;
    port_i = 8'h05;
    iowr   = 1'b1;
    cyc(1);
    check_eq("border_latency", 32'(border), 32'h111);
    port_i = 8'h02;
    cyc(1);
    check_eq("border_new", 32'(border), 32'h808);
    check_eq("border_read", 32'(port_o), 32'h05);
    cyc(1);
    iowr = 1'b0;
    cyc(1);
    check_eq("border_single_write", 32'(border), 32'h808);
    check_eq("border_read_hold", 32'(port_o), 32'h05);

    // Interrupt timeout
    io_write(8'hFD, 8'h01);
    vs_pulse();
    check_eq("irq_raise", 32'(irq), 32'h1);
    cyc(1);
    check_eq("ctrl_irq_read", 32'(port_o), 32'h81);
    irq_high_len(1, k);
    check_eq("irq_timeout_len", 32'(k), 32'd800);
    io_read(8'hFC, rd);
    check_eq("frame_one", 32'(rd), 32'h01);
    io_read(8'hFD, rd);
    check_eq("ctrl_after_timeout", 32'(rd), 32'h01);

    // Acknowledge, then re-raise 50 cycles later
    vs_pulse();
    cyc(9);
    check_eq("irq_before_ack", 32'(irq), 32'h1);
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    check_eq("irq_acked", 32'(irq), 32'h0);
    cyc(49);
    vs_pulse();
    check_eq("irq_reraise", 32'(irq), 32'h1);
    io_read(8'hFD, rd);
    check_eq("ctrl_no_ovr", 32'(rd), 32'h81);
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    check_eq("irq_acked2", 32'(irq), 32'h0);

    // Overrun: two rises 100 cycles apart
    vs_pulse();
    cyc(99);
    port_a = 8'hFD;
    vs_pulse();
    check_eq("ovr_irq", 32'(irq), 32'h1);
    cyc(1);
    check_eq("ovr_ctrl_read", 32'(port_o), 32'hC1);
    irq_high_len(1, k);
    check_eq("ovr_irq_len", 32'(k), 32'd800);
    io_read(8'hFD, rd);
    check_eq("ovr_sticky", 32'(rd), 32'h41);
    io_read(8'hFC, rd);
    check_eq("frame_five", 32'(rd), 32'h05);
    io_write(8'hFD, 8'hC1);
    io_read(8'hFD, rd);
    check_eq("ovr_cleared", 32'(rd), 32'h01);
    io_read(8'hFC, rd);
    check_eq("frame_cleared", 32'(rd), 32'h00);

    // Frame counter wrap
    for (int i = 0; i < 255; i++) begin
      vs_pulse();
      cyc(1);
    end
    io_read(8'hFC, rd);
    check_eq("frame_ff", 32'(rd), 32'hFF);
    vs_pulse();
    cyc(1);
    io_read(8'hFC, rd);
    check_eq("frame_wrap", 32'(rd), 32'h00);

    // Rise together with irq_ack
    io_write(8'hFD, 8'h41);
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    check_eq("irq_dropped_pre", 32'(irq), 32'h0);
    vsync   = 1'b1;
    irq_ack = 1'b1;
    cyc(1);
    check_eq("rise_beats_ack", 32'(irq), 32'h1);
    vsync   = 1'b0;
    irq_ack = 1'b0;
    cyc(1);
    vsync   = 1'b1;
    irq_ack = 1'b1;
    cyc(1);
    check_eq("rise_beats_ack2", 32'(irq), 32'h1);
    vsync   = 1'b0;
    irq_ack = 1'b0;
    io_read(8'hFD, rd);
    check_eq("rise_ack_ovr", 32'(rd), 32'hC1);

    // Rise together with CTRL write of 8'h80
    port_a = 8'hFD;
    port_i = 8'h80;
    iowr   = 1'b1;
    vsync  = 1'b1;
    cyc(1);
    iowr  = 1'b0;
    vsync = 1'b0;
    check_eq("rise_ie_off_irq", 32'(irq), 32'h0);
    cyc(1);
    check_eq("rise_clr_ctrl", 32'(port_o), 32'h40);
    io_read(8'hFC, rd);
    check_eq("rise_clr_frame", 32'(rd), 32'h00);

    // Rise together with enabling ie: not yet effective
    port_a = 8'hFD;
    port_i = 8'h01;
    iowr   = 1'b1;
    vsync  = 1'b1;
    cyc(1);
    iowr  = 1'b0;
    vsync = 1'b0;
    check_eq("rise_ie_on_irq", 32'(irq), 32'h0);
    io_read(8'hFD, rd);
    check_eq("rise_ie_on_ctrl", 32'(rd), 32'h41);
    io_read(8'hFC, rd);
    check_eq("rise_ie_on_frame", 32'(rd), 32'h01);

    // Asynchronous reset in the middle of an interrupt
    vs_pulse();
    check_eq("pre_reset_irq", 32'(irq), 32'h1);
    check_eq("pre_reset_border", 32'(border), 32'h808);
    #3;
    rst = 1'b1;
    #1;
    check_eq("async_rst_irq", 32'(irq), 32'h0);
    check_eq("async_rst_border", 32'(border), 32'h111);
    check_eq("async_rst_port_o", 32'(port_o), 32'hFF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    io_read(8'hFC, rd);
    check_eq("async_rst_frame", 32'(rd), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
